// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Borrow is needed when y exceeds x, or when they match and a borrow comes in.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial word subtractor: diff = a - b - bin, processed LSB-first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for operands; in_ready high
// SHIFT | one result bit per edge through the full-subtractor cell
// DONE  | result held on diff/bout(/ovf) until out_ready handshake
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] diff_next;
`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept because a_sr/b_sr are shifted away by the end of the word.
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign in_ready  = (state == IDLE);
  assign diff_next = {cell_d, diff_sr[WIDTH-1:1]};

  // Control FSM and serial datapath; the final bit is merged straight into diff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      diff_sr   <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          diff_sr <= diff_next;
          borrow  <= cell_bo;
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          if (cnt == CNT_LAST) begin
            diff      <= diff_next;
            bout      <= cell_bo;
            out_valid <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= (a_msb != b_msb) & (cell_d != a_msb);
`endif
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed and random words on WIDTH=8,
// plus an exhaustive sweep on a WIDTH=3 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [7:0] a, b, diff;
  logic       in_valid3, in_ready3, bin3, out_valid3, out_ready3, bout3;
  logic [2:0] a3, b3, diff3;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .a         (a3),
    .b         (b3),
    .bin       (bin3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .diff      (diff3),
    .bout      (bout3)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned subtraction widened by one bit gives {borrow, diff}.
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {8'd0, bi};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WIDTH=8 instance, with `hold` cycles of backpressure.
  task automatic run_word(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, input int hold);
    logic [8:0] exp;
    int n;
    exp = ref_sub(ta, tb, tbin);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    step();
    // Junk operands with in_valid high must not disturb the word in flight.
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd8);
    chk("diff", 32'(diff), 32'(exp[7:0]));
    chk("bout", 32'(bout), 32'(exp[8]));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(ovf), 32'((ta[7] != tb[7]) && (exp[7] != ta[7])));
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_diff", 32'(diff), 32'(exp[7:0]));
      chk("hold_bout", 32'(bout), 32'(exp[8]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] exp3;
    logic       seen;
    int         n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = '0; b3 = '0; bin3 = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_word(8'h05, 8'h03, 1'b0, 0);
    run_word(8'h00, 8'h01, 1'b0, 0);
    run_word(8'h10, 8'h10, 1'b1, 0);
    run_word(8'h10, 8'h10, 1'b0, 1);
    run_word(8'hA5, 8'h3C, 1'b1, 5);
    run_word(8'h80, 8'h01, 1'b0, 0);
    run_word(8'h7F, 8'hFF, 1'b0, 0);
    run_word(8'h03, 8'h01, 1'b0, 0);
    run_word(8'hFF, 8'hFF, 1'b1, 0);

    // Reset in the middle of a word: it must vanish without a result.
    a = 8'h55; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_diff", 32'(diff), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    run_word(8'h09, 8'h04, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      run_word(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Exhaustive WIDTH=3 sweep, back-to-back with out_ready held high.
    for (int k = 0; k < 128; k++) begin
      n = 0;
      while (!in_ready3 && n < 20) begin
        step();
        n++;
      end
      a3 = 3'(k >> 4); b3 = 3'(k >> 1); bin3 = 1'(k);
      in_valid3 = 1'b1;
      step();
      in_valid3 = 1'b0;
      n = 0;
      while (!out_valid3 && n < 20) begin
        step();
        n++;
      end
      exp3 = {1'b0, a3} - {1'b0, b3} - {3'd0, bin3};
      chk("w3_result", 32'({bout3, diff3}), 32'(exp3));
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
